// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared types and constants for the instruction-fetch stage.
//   INST_ADDR_W / INST_W : instruction address and instruction bus widths
//   IF_NOP_INST          : instruction presented to decode on a bubble
//   if_state_e           : fetch FSM state encoding (2-bit)
//   pc_inc()             : 16-bit wrapping PC increment
package if_fetch_pkg;

    localparam int INST_ADDR_W = 16;
    localparam int INST_W      = 16;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_t IF_NOP_INST = 16'h0800;

    typedef enum logic [1:0] {
        IF_S_IDLE  = 2'd0,
        IF_S_FETCH = 2'd1,
        IF_S_HOLD  = 2'd2,
        IF_S_GAP   = 2'd3
    } if_state_e;

    // Wraps FFFF -> 0000 by construction of the 16-bit result.
    function automatic inst_addr_t pc_inc(input inst_addr_t pc);
        return pc + inst_addr_t'(1);
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory req/ack port.
//   req   : fetch request, held until ack (master -> slave)
//   addr  : fetch address, stable while req is high (master -> slave)
//   ack   : request accepted, rdata valid this cycle (slave -> master)
//   rdata : fetched instruction (slave -> master)
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic       req;
    inst_addr_t addr;
    logic       ack;
    inst_t      rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);

endinterface

// File: rtl/if_fetch_hold_buf.sv
// if_fetch_hold_buf: one-entry pc/inst skid register. Catches an instruction
// that completes while the pipeline is stalled so it can be handed to decode
// once the stall lifts.
//   clk, rst          : clock, async active-low reset
//   load              : capture pc_in/inst_in, set valid
//   unload            : entry consumed, clear valid
//   pc_in, inst_in    : data to capture
//   valid             : entry holds an undelivered instruction
//   pc_out, inst_out  : captured data
module if_fetch_hold_buf
    import if_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       unload,
    input  inst_addr_t pc_in,
    input  inst_t      inst_in,
    output logic       valid,
    output inst_addr_t pc_out,
    output inst_t      inst_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= 1'b0;
            pc_out   <= '0;
            inst_out <= IF_NOP_INST;
        end else if (load) begin
            valid    <= 1'b1;
            pc_out   <= pc_in;
            inst_out <= inst_in;
        end else if (unload) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the PC, fetches over a req/ack
// memory port and delivers one instruction per completed fetch to decode.
// Handles one-delay-slot branch redirects and pipeline stalls.
//
// Optional build macro IF_REISSUE_EN: a fetch left unacknowledged for
// TIMEOUT cycles drops req for one cycle (S_GAP), pulses timeout_o and
// reissues the same address. Without it the stage waits indefinitely and
// timeout_o is tied low.
//
// Ports:
//   clk, rst        : clock, async active-low reset
//   stall_i         : freeze IF/ID outputs
//   branch_flag_i   : redirect request (ignored while stalled)
//   branch_addr_i   : redirect target
//   imem            : instruction-memory port (master side)
//   pc_o            : delivered fetch address + 1
//   inst_o          : delivered instruction (NOP on a bubble)
//   inst_valid_o    : inst_o is a real instruction
//   timeout_o       : one-cycle pulse on reissue
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IF_S_IDLE  | one cycle after reset release, no request
// IF_S_FETCH | req high at pc_fetch, waiting for / taking ack
// IF_S_HOLD  | stalled with a completed fetch parked in the hold buffer
// IF_S_GAP   | req dropped one cycle before reissuing (IF_REISSUE_EN only)
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t  RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  inst_addr_t        branch_addr_i,
    if_fetch_if.master        imem,
    output inst_addr_t        pc_o,
    output inst_t             inst_o,
    output logic              inst_valid_o,
    output logic              timeout_o
);

    if_state_e  state;
    if_state_e  state_nxt;
    inst_addr_t pc_fetch;
    inst_addr_t pc_fetch_nxt;
    logic       redir_pend;
    inst_addr_t redir_addr;

    logic       req;
    logic       complete;
    logic       deliver;
    logic       capture;
    logic       unload;
    logic       bubble;
    logic       go_gap;
    logic       gap_pulse;
    logic       take_branch;

    logic       buf_valid;
    inst_addr_t buf_pc;
    inst_t      buf_inst;

`ifdef IF_REISSUE_EN
    logic [3:0] wait_cnt;
`endif

    // Stall masks the redirect entirely; decode re-presents it later.
    assign take_branch = branch_flag_i & ~stall_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IF_S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        complete  = 1'b0;
        deliver   = 1'b0;
        capture   = 1'b0;
        unload    = 1'b0;
        bubble    = 1'b0;
        go_gap    = 1'b0;
        gap_pulse = 1'b0;
        case (state)
            IF_S_IDLE: begin
                state_nxt = IF_S_FETCH;
            end
            IF_S_FETCH: begin
                req = 1'b1;
                if (imem.ack) begin
                    complete = 1'b1;
                    if (stall_i) begin
                        capture   = 1'b1;
                        state_nxt = IF_S_HOLD;
                    end else begin
                        deliver   = 1'b1;
                    end
                end else begin
                    bubble = ~stall_i;
`ifdef IF_REISSUE_EN
                    if (wait_cnt == 4'(TIMEOUT - 1)) begin
                        go_gap    = 1'b1;
                        state_nxt = IF_S_GAP;
                    end
`endif
                end
            end
            IF_S_HOLD: begin
                if (!stall_i && buf_valid) begin
                    unload    = 1'b1;
                    state_nxt = IF_S_FETCH;
                end
            end
`ifdef IF_REISSUE_EN
            IF_S_GAP: begin
                gap_pulse = 1'b1;
                bubble    = ~stall_i;
                state_nxt = IF_S_FETCH;
            end
`endif
            default: begin
                state_nxt = IF_S_IDLE;
            end
        endcase
    end

    // Same-edge redirect wins: the completing fetch is the delay slot.
    always_comb begin
        pc_fetch_nxt = pc_inc(pc_fetch);
        if (take_branch) begin
            pc_fetch_nxt = branch_addr_i;
        end else if (redir_pend) begin
            pc_fetch_nxt = redir_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_fetch     <= RESET_PC;
            redir_pend   <= 1'b0;
            redir_addr   <= '0;
            pc_o         <= '0;
            inst_o       <= IF_NOP_INST;
            inst_valid_o <= 1'b0;
        end else begin
            if (deliver) begin
                pc_o         <= pc_inc(pc_fetch);
                inst_o       <= imem.rdata;
                inst_valid_o <= 1'b1;
            end else if (unload) begin
                pc_o         <= buf_pc;
                inst_o       <= buf_inst;
                inst_valid_o <= 1'b1;
            end else if (bubble) begin
                inst_o       <= IF_NOP_INST;
                inst_valid_o <= 1'b0;
            end

            if (complete) begin
                pc_fetch   <= pc_fetch_nxt;
                redir_pend <= 1'b0;
            end else if (take_branch) begin
                redir_pend <= 1'b1;
                redir_addr <= branch_addr_i;
            end
        end
    end

    if_fetch_hold_buf u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (capture),
        .unload   (unload),
        .pc_in    (pc_inc(pc_fetch)),
        .inst_in  (imem.rdata),
        .valid    (buf_valid),
        .pc_out   (buf_pc),
        .inst_out (buf_inst)
    );

`ifdef IF_REISSUE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != IF_S_FETCH || complete || go_gap) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign timeout_o = gap_pulse;
`else
    logic unused_timeout;
    assign unused_timeout = (^TIMEOUT) ^ go_gap ^ gap_pulse;
    assign timeout_o      = 1'b0;
`endif

    // Address is forced to zero outside S_FETCH so reset shows 0 regardless of RESET_PC.
    assign imem.req  = req;
    assign imem.addr = req ? pc_fetch : '0;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall = 1'b0;
    logic       branch_flag = 1'b0;
    inst_addr_t branch_addr = '0;
    inst_addr_t pc;
    inst_t      inst;
    logic       inst_valid;
    logic       timeout;

    if_fetch_if imem();

    if_fetch #(.RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .branch_flag_i (branch_flag),
        .branch_addr_i (branch_addr),
        .imem          (imem),
        .pc_o          (pc),
        .inst_o        (inst),
        .inst_valid_o  (inst_valid),
        .timeout_o     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } item_t;

    item_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    // reference model of the fetch stage
    inst_addr_t m_addr, m_pa, m_pc;
    inst_t      m_inst;
    logic       m_valid, m_pend, m_idle, m_held, m_gap;
`ifdef IF_REISSUE_EN
    int         m_tcnt;
`endif
    // memory model
    int         ack_delay;
    logic       ack_en;
    int         mem_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr  = 16'h0000;
        m_pa    = '0;
        m_pend  = 1'b0;
        m_idle  = 1'b1;
        m_held  = 1'b0;
        m_gap   = 1'b0;
        m_pc    = '0;
        m_inst  = 16'h0800;
        m_valid = 1'b0;
`ifdef IF_REISSUE_EN
        m_tcnt  = 0;
`endif
        mem_cnt = 0;
        sb.delete();
    endtask

    // Called at a negedge with stall/branch already set for the coming edge.
    task automatic step();
        logic  m_req, cmpl, take, st;
        item_t it;
        m_req = !m_idle && !m_held && !m_gap;
        chk("req", imem.req, m_req);
        chk("timeout", timeout, m_gap);
        if (m_req) chk("addr", imem.addr, m_addr);

        imem.ack   = ack_en && imem.req && (mem_cnt >= ack_delay);
        imem.rdata = imem.addr ^ 16'hA000;
        cmpl = m_req && imem.ack;
        take = branch_flag && !stall;
        st   = stall;
        assert (!(take && m_pend)) else $error("protocol: redirect issued while one is pending");

        if (cmpl) begin
            it.pc   = m_addr + 16'd1;
            it.inst = m_addr ^ 16'hA000;
            sb.push_back(it);
        end
        if (!st) begin
            if (cmpl || m_held) begin
                chk("sb_depth", sb.size(), 1);
                if (sb.size() > 0) begin
                    it      = sb.pop_front();
                    m_pc    = it.pc;
                    m_inst  = it.inst;
                    m_valid = 1'b1;
                end
            end else begin
                m_inst  = 16'h0800;
                m_valid = 1'b0;
            end
        end

        mem_cnt = (imem.req && !imem.ack) ? mem_cnt + 1 : 0;
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_held) begin
            if (!st) m_held = 1'b0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (cmpl) begin
`ifdef IF_REISSUE_EN
            m_tcnt = 0;
`endif
            if (st) m_held = 1'b1;
        end else begin
`ifdef IF_REISSUE_EN
            if (m_tcnt == TIMEOUT - 1) begin
                m_gap  = 1'b1;
                m_tcnt = 0;
            end else begin
                m_tcnt++;
            end
`endif
        end
        if (cmpl) begin
            m_addr = take ? branch_addr : (m_pend ? m_pa : m_addr + 16'd1);
            m_pend = 1'b0;
        end else if (take) begin
            m_pend = 1'b1;
            m_pa   = branch_addr;
        end

        @(posedge clk);
        @(negedge clk);
        chk("valid", inst_valid, m_valid);
        chk("inst", inst, m_inst);
        chk("pc", pc, m_pc);
    endtask

    initial begin
        imem.ack   = 1'b0;
        imem.rdata = '0;
        ack_en     = 1'b1;
        ack_delay  = 0;
        model_reset();
        repeat (2) @(negedge clk);

        chk("rst_req", imem.req, 0);
        chk("rst_addr", imem.addr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_inst", inst, 16'h0800);
        chk("rst_valid", inst_valid, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b1;

        // back-to-back zero-wait fetches
        repeat (6) step();

        // three-cycle ack delay on address 5
        chk("t2_addr", imem.addr, 16'h0005);
        ack_delay = 3;
        repeat (4) step();
        ack_delay = 0;

        // redirect completing on the same edge as the delay slot
        for (int i = 0; i < 20 && m_addr != 16'h0011; i++) step();
        branch_flag = 1'b1;
        branch_addr = 16'h0040;
        step();
        branch_flag = 1'b0;
        chk("t3_target", imem.addr, 16'h0040);
        repeat (2) step();

        // redirect while the delay-slot fetch is still waiting
        ack_delay   = 2;
        branch_flag = 1'b1;
        branch_addr = 16'h0080;
        step();
        branch_flag = 1'b0;
        repeat (5) step();
        ack_delay = 0;

        // stall with completion in the first stalled cycle
        stall = 1'b1;
        repeat (2) step();
        stall = 1'b0;
        repeat (3) step();

        // stall while waiting for ack, plus a redirect masked by stall
        ack_delay   = 2;
        stall       = 1'b1;
        branch_flag = 1'b1;
        branch_addr = 16'h1234;
        step();
        branch_flag = 1'b0;
        step();
        stall = 1'b0;
        repeat (3) step();
        ack_delay = 0;

        // PC wrap
        branch_flag = 1'b1;
        branch_addr = 16'hFFFE;
        step();
        branch_flag = 1'b0;
        repeat (4) step();

        // asynchronous reset with a request outstanding
        chk("pre_rst_req", imem.req, 1);
        imem.ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_req", imem.req, 0);
        chk("arst_addr", imem.addr, 0);
        chk("arst_pc", pc, 0);
        chk("arst_inst", inst, 16'h0800);
        chk("arst_valid", inst_valid, 0);
        chk("arst_timeout", timeout, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // memory that never answers
        ack_en = 1'b0;
`ifdef IF_REISSUE_EN
        repeat (TIMEOUT + 1) step();
        ack_en = 1'b1;
        repeat (3) step();
`else
        repeat (20) step();
        ack_en = 1'b1;
        repeat (3) step();
`endif

        // randomised mix of stalls, wait states and redirects
        repeat (300) begin
            stall       = ($urandom_range(0, 3) == 0);
            ack_delay   = $urandom_range(0, 2);
            branch_flag = !m_pend && ($urandom_range(0, 7) == 0);
            branch_addr = 16'($urandom);
            step();
        end
        stall       = 1'b0;
        branch_flag = 1'b0;
        ack_delay   = 0;
        repeat (4) step();
        chk("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Delivers one instruction per acknowledged fetch to the decode stage as pc/inst/valid.
- Accepts branch redirects and pipeline stalls from decode and ctrl.
- Sits between the instruction-memory port and the IF/ID boundary. It is the producer side of the pc_i/inst_i and branch_flag/branch_addr interface that decode consumes.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- TIMEOUT, 15, wait cycles before reissue (used only with IF_REISSUE_EN); 4-bit counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall_i  input  1  pipeline stall from ctrl; freezes IF/ID outputs.
- branch_flag_i  input  1  redirect request from decode.
- branch_addr_i  input  16  redirect target.
- imem_req_o  output  1  fetch request, held until ack.
- imem_addr_o  output  16  fetch address.
- imem_ack_i  input  1  memory accepted request; rdata valid this cycle.
- imem_rdata_i  input  16  fetched instruction.
- pc_o  output  16  fetch address of delivered instruction + 1, used by decode as branch/MFPC base.
- inst_o  output  16  delivered instruction.
- inst_valid_o  output  1  inst_o is a real instruction.
- timeout_o  output  1  1-cycle pulse on reissue (optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE, pc_fetch=RESET_PC.
  - pc_o=0, inst_o=16'h0800 (NOP), inst_valid_o=0, imem_req_o=0, imem_addr_o=0, timeout_o=0.
  - Hold buffer, redirect-pending flag and wait counter cleared.
- Reset mid-fetch drops imem_req_o immediately. Memory must ignore an ack that arrives while rst=0.
- S_IDLE: one cycle after reset release, then S_FETCH.
- S_FETCH:
  - imem_req_o=1, imem_addr_o=pc_fetch. Address is stable until ack.
  - A transaction completes on an edge with req=1 and ack=1. Zero-wait ack in the same cycle is legal, giving 1 instruction/cycle throughput.
- On completion with stall_i=0:
  - inst_o<=rdata, pc_o<=pc_fetch+1, inst_valid_o<=1.
  - pc_fetch<=pc_fetch+1 (16-bit wrap, FFFF->0000), or redirect target if one is pending.
- Any S_FETCH edge without completion and stall_i=0: inst_o<=16'h0800, inst_valid_o<=0 (bubble). Decode therefore never sees the same valid instruction twice.
- On completion with stall_i=1:
  - rdata and pc_fetch+1 go into the hold buffer; IF/ID outputs unchanged.
  - Enter S_HOLD with imem_req_o=0.
  - pc_fetch advances as normal.
- S_HOLD:
  - No request issued; outputs frozen while stall_i=1.
  - First edge with stall_i=0: buffer -> outputs with valid=1, then S_FETCH.
- stall_i=1 in S_FETCH without ack: request stays asserted, outputs frozen.
- Redirect:
  - branch_flag_i is honoured only on edges with stall_i=0; it is ignored while stalled.
  - One delay slot: the fetch in flight, or the one completing on the same edge, is delivered normally.
  - If the completion is on the same edge: pc_fetch<=branch_addr_i.
  - Otherwise: redir_pend<=1, redir_addr<=branch_addr_i. The next completion delivers the delay slot, loads pc_fetch<=redir_addr and clears redir_pend.
  - A second branch_flag_i while redir_pend=1 overwrites redir_addr. Decode must not do this; the bench flags it as an assertion.

Optional Feature:
- IF_REISSUE_EN defined:
  - In S_FETCH, a 4-bit counter counts cycles with req=1, ack=0.
  - When it reaches TIMEOUT: go to S_GAP (req=0, 1 cycle), pulse timeout_o, clear counter, reissue the same imem_addr_o.
  - Stall and redirect-pending state are preserved across the gap.
- Undefined: no counter and no S_GAP; waits indefinitely; timeout_o tied 0.

Decomposition:
- defines.v gets:
  - IF_NOP_INST (16'h0800).
  - State encodings IF_S_IDLE/IF_S_FETCH/IF_S_HOLD/IF_S_GAP (2-bit).
  - The existing InstAddrBus/InstBus widths.
- One sub-module, if_hold_buf: 1-entry pc/inst skid register with load/unload/valid.

Test Plan:
1. Reset release with RESET_PC=0 and always-ack memory returning addr^16'hA000 -> addresses 0,1,2 issued on consecutive cycles; inst_o A000/A001/A002 with pc_o 1/2/3, valid every cycle.
2. Ack delayed 3 cycles on addr 5 -> imem_addr_o stable at 5 for 4 cycles, 3 bubble cycles (inst_o=0800, valid=0), then inst delivered with pc_o=6.
3. branch_flag_i=1, branch_addr_i=0x0040 while fetch of 0x11 is in flight -> 0x11 is still delivered (delay slot), next imem_addr_o=0x0040.
4. stall_i=1 for 2 cycles, ack arriving in the first stalled cycle -> outputs frozen, req low in S_HOLD; when stall drops, the buffered instruction appears once and fetch resumes at the following address.
5. pc_fetch=FFFF -> delivered pc_o=0000, next address 0000. rst pulled low with req high -> all outputs at reset values asynchronously.
6. With IF_REISSUE_EN and no ack -> after 15 wait cycles, req low for 1 cycle and timeout_o pulses; reissue at the same address is then acked normally.
